// File: rtl/uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_ctrl
//   Drains completed bytes from the UART receiver (rx_valid / rx_read
//   handshake) into a small first-word-fall-through FIFO. The FIFO is offered
//   to the bus through a ready/valid pop port. The module also drives the UART
//   RTS pin (active low): the receiver's own RTS OR'd with a FIFO-almost-full
//   throttle. A sticky overrun flag records bytes that were dropped because
//   the FIFO was full.
//
// Optional feature (compile-time macro UART_RX_TIMEOUT_EN):
//   When defined, rx_timeout rises once the FIFO has held data with no push or
//   pop for TIMEOUT_CYCLES-1 consecutive cycles. It falls on the next push,
//   on the next pop, or when the FIFO is empty. When the macro is undefined,
//   rx_timeout is tied to 0.
//
// Ports
//   clk          in   system clock
//   resetn       in   synchronous, active-low reset
//   rx_valid     in   receiver holds a completed byte
//   rx_data      in   receiver byte, stable while rx_valid
//   rx_rts       in   receiver RTS (active low)
//   rx_read      out  one-cycle pulse: byte consumed, receiver may clear
//   uart_rts     out  RTS pin (active low), registered
//   rd_valid     out  FIFO non-empty
//   rd_data      out  FIFO head (first-word fall-through)
//   rd_ready     in   pop head when rd_valid & rd_ready
//   fill         out  current entry count, 0..FIFO_DEPTH
//   overrun      out  sticky: byte arrived while FIFO full
//   overrun_clr  in   clears overrun (a same-cycle new overrun wins)
//   rx_timeout   out  idle-with-data flag
// ---------------------------------------------------------------------------
module uart_rx_fifo_ctrl #(
  parameter int PAYLOAD_BITS   = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int RTS_THRESH     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         rx_valid,
  input  logic [PAYLOAD_BITS-1:0]      rx_data,
  input  logic                         rx_rts,
  output logic                         rx_read,
  output logic                         uart_rts,
  output logic                         rd_valid,
  output logic [PAYLOAD_BITS-1:0]      rd_data,
  input  logic                         rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fill,
  output logic                         overrun,
  input  logic                         overrun_clr,
  output logic                         rx_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(RTS_THRESH);
  localparam logic [CW-1:0] ZERO_C   = CW'(0);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACK  = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;

  logic                     capture_s;
  logic                     rx_read_next_s;
  logic                     rx_read_r;

  logic [PAYLOAD_BITS-1:0]  mem_r [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_r;
  logic [AW-1:0]            rd_ptr_r;
  logic [CW-1:0]            count_r;
  logic [CW-1:0]            count_next_s;

  logic                     rd_valid_r;
  logic                     pop_s;
  logic                     full_s;
  logic                     push_s;
  logic                     drop_s;

  logic                     overrun_r;
  logic                     uart_rts_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: WAIT holds until the receiver drops rx_valid so a held
  // byte is never captured twice.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid) begin
          state_next_s = ST_ACK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (!rx_valid) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: capture the byte and request the rx_read pulse from IDLE only.
  always_comb begin
    capture_s      = 1'b0;
    rx_read_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid) begin
          capture_s      = 1'b1;
          rx_read_next_s = 1'b1;
        end else begin
          capture_s      = 1'b0;
          rx_read_next_s = 1'b0;
        end
      end
      ST_ACK: begin
        capture_s      = 1'b0;
        rx_read_next_s = 1'b0;
      end
      ST_WAIT: begin
        capture_s      = 1'b0;
        rx_read_next_s = 1'b0;
      end
      default: begin
        capture_s      = 1'b0;
        rx_read_next_s = 1'b0;
      end
    endcase
  end

  // Push/pop qualification. A full FIFO still accepts a byte when the head
  // leaves in the same cycle. Otherwise the byte is dropped but still
  // acknowledged.
  always_comb begin
    pop_s  = rd_valid_r & rd_ready;
    full_s = (count_r == DEPTH_C);
    push_s = capture_s & (~full_s | pop_s);
    drop_s = capture_s & full_s & ~pop_s;
  end

  // Next fill level; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_C;
      2'b01:   count_next_s = count_r - ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage and pointers; pointers wrap naturally (depth is a power of two).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {PAYLOAD_BITS{1'b0}};
      end
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= ZERO_C;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= rx_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
      end else begin
        wr_ptr_r        <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_next_s;
    end
  end

  // Registered status outputs: rx_read pulse, rd_valid, RTS throttle, sticky overrun.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_read_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      uart_rts_r <= 1'b1;
      overrun_r  <= 1'b0;
    end else begin
      rx_read_r  <= rx_read_next_s;
      rd_valid_r <= (count_next_s != ZERO_C);
      uart_rts_r <= rx_rts | (count_next_s >= THRESH_C);
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST_C = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_r;
  logic [TW-1:0] tmo_cnt_next_s;
  logic          rx_timeout_r;

  // Idle counter: restarts on any FIFO activity or when empty, saturates at the last value.
  always_comb begin
    tmo_cnt_next_s = tmo_cnt_r;
    if (push_s | pop_s | (count_r == ZERO_C)) begin
      tmo_cnt_next_s = TW'(0);
    end else if (tmo_cnt_r != TMO_LAST_C) begin
      tmo_cnt_next_s = tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_next_s = tmo_cnt_r;
    end
  end

  // Timeout counter and flag registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt_r    <= TW'(0);
      rx_timeout_r <= 1'b0;
    end else begin
      tmo_cnt_r    <= tmo_cnt_next_s;
      rx_timeout_r <= (tmo_cnt_next_s == TMO_LAST_C);
    end
  end

  assign rx_timeout = rx_timeout_r;
`else
  // Timeout logic compiled out; the parameter is still referenced so both
  // builds elaborate with the same parameter set.
  localparam logic TMO_CFG_OK_C = 1'(TIMEOUT_CYCLES >= 2);
  assign rx_timeout = TMO_CFG_OK_C & 1'b0;
`endif

  assign rx_read  = rx_read_r;
  assign uart_rts = uart_rts_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = mem_r[rd_ptr_r];
  assign fill     = count_r;
  assign overrun  = overrun_r;

endmodule
